// File: rtl/pb_uart_regs_mc.sv
// PicoBlaze port-mapped register file for N UART channels: per-channel windows,
// sticky W1C interrupt sources, atomic 16-bit divisor update, acked level interrupt.

module pb_uart_ch #(
    parameter logic [15:0] DEFAULT_DIVIDE = 16'd54
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic        rd,
    input  logic [2:0]  offset,
    input  logic [7:0]  data_in,
    input  logic [7:0]  uart_data_read,
    input  logic        rx_data_present,
    input  logic        rx_half_full,
    input  logic        rx_full,
    input  logic        tx_data_present,
    input  logic        tx_half_full,
    input  logic        tx_full,
    output logic        buffer_write,
    output logic [7:0]  uart_data_write,
    output logic        buffer_read,
    output logic        enable,
    output logic [15:0] uart_clock_divide,
    output logic [7:0]  rd_data,
    output logic        irq,
    output logic        new_evt
);
    logic [7:0] control, shadow_lo;
    logic [3:0] mask, pend, set_vec, clr_vec;
    logic       rxp_q, rxf_q, txp_q;
    logic       wr_data, tx_drop;

    assign wr_data = wr && (offset == 3'd0);
    assign tx_drop = wr_data && tx_full;
    // Sources: [0] rx present rise, [1] rx full rise, [2] tx went empty, [3] tx overflow
    assign set_vec = {tx_drop, txp_q & ~tx_data_present, rx_full & ~rxf_q, rx_data_present & ~rxp_q};
    assign clr_vec = (wr && offset == 3'd4) ? data_in[3:0] : 4'h0;
    assign irq     = |(pend & mask);
    assign new_evt = |(set_vec & ~pend & mask);
    assign enable  = control[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            control           <= 8'h00;
            mask              <= 4'h0;
            pend              <= 4'h0;
            shadow_lo         <= DEFAULT_DIVIDE[7:0];
            uart_clock_divide <= DEFAULT_DIVIDE;
            buffer_write      <= 1'b0;
            buffer_read       <= 1'b0;
            uart_data_write   <= 8'h00;
            rxp_q             <= rx_data_present;
            rxf_q             <= rx_full;
            txp_q             <= tx_data_present;
        end else begin
            rxp_q        <= rx_data_present;
            rxf_q        <= rx_full;
            txp_q        <= tx_data_present;
            pend         <= (pend & ~clr_vec) | set_vec;
            buffer_write <= wr_data && !tx_full;
            buffer_read  <= rd && (offset == 3'd0) && rx_data_present;
            if (wr_data && !tx_full) uart_data_write <= data_in;
            if (wr) begin
                case (offset)
                    3'd1: control           <= data_in;
                    3'd3: mask              <= data_in[3:0];
                    3'd5: shadow_lo         <= data_in;
                    3'd6: uart_clock_divide <= {data_in, shadow_lo};
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (offset)
            3'd0: if (rx_data_present) rd_data = uart_data_read;
            3'd1: rd_data = control;
            3'd2: rd_data = {2'b00, tx_full, tx_half_full, tx_data_present,
                             rx_full, rx_half_full, rx_data_present};
            3'd3: rd_data = {4'h0, mask};
            3'd4: rd_data = {4'h0, pend};
            3'd5: rd_data = shadow_lo;
            3'd6: rd_data = uart_clock_divide[15:8];
            default: rd_data = 8'h00;
        endcase
    end
endmodule

module pb_uart_regs_mc #(
    parameter logic [7:0]  BASE_ADDRESS   = 8'h00,
    parameter int          N_CHANNELS     = 2,
    parameter int          CH_STRIDE      = 8,
    parameter logic [15:0] DEFAULT_DIVIDE = 16'd54
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              port_id,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    input  logic                    read_strobe,
    input  logic                    write_strobe,
    output logic                    interrupt,
    input  logic                    interrupt_ack,
    output logic [N_CHANNELS-1:0]   buffer_write,
    output logic [8*N_CHANNELS-1:0] uart_data_write,
    output logic [N_CHANNELS-1:0]   buffer_read,
    input  logic [8*N_CHANNELS-1:0] uart_data_read,
    input  logic [N_CHANNELS-1:0]   rx_data_present,
    input  logic [N_CHANNELS-1:0]   rx_half_full,
    input  logic [N_CHANNELS-1:0]   rx_full,
    input  logic [N_CHANNELS-1:0]   tx_data_present,
    input  logic [N_CHANNELS-1:0]   tx_half_full,
    input  logic [N_CHANNELS-1:0]   tx_full,
    output logic [N_CHANNELS-1:0]   enable,
    output logic [16*N_CHANNELS-1:0] uart_clock_divide
);
    localparam int SW      = $clog2(CH_STRIDE);
    localparam int SUM_OFF = N_CHANNELS * CH_STRIDE;

    typedef enum logic [1:0] {IDLE, ASSERTED, ACKED} irq_state_t;
    irq_state_t state, state_nx;

    logic [8:0] off9;
    logic [7:0] off, ch_sel, sub, rd_mux;
    logic       win_hit, summary_hit, any_irq, any_new;
    logic [N_CHANNELS-1:0]      ch_hit, irq_vec, evt_vec;
    logic [N_CHANNELS-1:0][7:0] rd_data;

    // A borrow out of the subtraction means port_id is below the block.
    assign off9        = {1'b0, port_id} - {1'b0, BASE_ADDRESS};
    assign off         = off9[7:0];
    assign ch_sel      = off >> SW;
    assign sub         = off & 8'(CH_STRIDE - 1);
    assign win_hit     = !off9[8] && (sub < 8'd8) && (ch_sel < 8'(N_CHANNELS));
    assign summary_hit = !off9[8] && (SUM_OFF < 256) && (off == 8'(SUM_OFF));

    genvar c;
    generate
        for (c = 0; c < N_CHANNELS; c++) begin : g_ch
            assign ch_hit[c] = win_hit && (ch_sel == 8'(c));
            pb_uart_ch #(.DEFAULT_DIVIDE(DEFAULT_DIVIDE)) u_ch (
                .clk               (clk),
                .reset             (reset),
                .wr                (write_strobe && ch_hit[c]),
                .rd                (read_strobe && ch_hit[c]),
                .offset            (sub[2:0]),
                .data_in           (data_in),
                .uart_data_read    (uart_data_read[8*c +: 8]),
                .rx_data_present   (rx_data_present[c]),
                .rx_half_full      (rx_half_full[c]),
                .rx_full           (rx_full[c]),
                .tx_data_present   (tx_data_present[c]),
                .tx_half_full      (tx_half_full[c]),
                .tx_full           (tx_full[c]),
                .buffer_write      (buffer_write[c]),
                .uart_data_write   (uart_data_write[8*c +: 8]),
                .buffer_read       (buffer_read[c]),
                .enable            (enable[c]),
                .uart_clock_divide (uart_clock_divide[16*c +: 16]),
                .rd_data           (rd_data[c]),
                .irq               (irq_vec[c]),
                .new_evt           (evt_vec[c])
            );
        end
    endgenerate

    assign any_irq = |irq_vec;
    assign any_new = |evt_vec;

    always_comb begin
        rd_mux = 8'h00;
        if (summary_hit) rd_mux = 8'(irq_vec);
        for (int i = 0; i < N_CHANNELS; i++)
            if (ch_hit[i]) rd_mux = rd_data[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 8'h00;
            state    <= IDLE;
        end else begin
            data_out <= rd_mux;
            state    <= state_nx;
        end
    end

    // ACKED holds off re-assertion until a fresh masked-in source fires.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (any_irq) state_nx = ASSERTED;
            ASSERTED: if (interrupt_ack) state_nx = ACKED;
                      else if (!any_irq) state_nx = IDLE;
            ACKED:    if (!any_irq) state_nx = IDLE;
                      else if (any_new) state_nx = ASSERTED;
            default:  state_nx = IDLE;
        endcase
    end

    assign interrupt = (state == ASSERTED);
endmodule

// File: tb/tb_pb_uart_regs_mc.sv
// Scoreboarded random/directed bench for pb_uart_regs_mc against a transaction-level register model.

module tb_pb_uart_regs_mc;
    localparam int N = 2;

    logic             clk = 1'b0, reset = 1'b1;
    logic [7:0]       port_id = 8'h00, data_in = 8'h00, data_out;
    logic             read_strobe = 1'b0, write_strobe = 1'b0, interrupt_ack = 1'b0, interrupt;
    logic [N-1:0]     buffer_write, buffer_read, enable;
    logic [8*N-1:0]   uart_data_write, udr = '0;
    logic [16*N-1:0]  uart_clock_divide;
    logic [N-1:0]     rxp = '0, rxh = '0, rxf = '0, txp = '0, txh = '0, txf = '0;

    pb_uart_regs_mc #(.BASE_ADDRESS(8'h00), .N_CHANNELS(N), .CH_STRIDE(8), .DEFAULT_DIVIDE(16'd54)) dut (
        .clk(clk), .reset(reset), .port_id(port_id), .data_in(data_in), .data_out(data_out),
        .read_strobe(read_strobe), .write_strobe(write_strobe), .interrupt(interrupt),
        .interrupt_ack(interrupt_ack), .buffer_write(buffer_write), .uart_data_write(uart_data_write),
        .buffer_read(buffer_read), .uart_data_read(udr), .rx_data_present(rxp), .rx_half_full(rxh),
        .rx_full(rxf), .tx_data_present(txp), .tx_half_full(txh), .tx_full(txf), .enable(enable),
        .uart_clock_divide(uart_clock_divide)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        bit             chk_data;
        logic [7:0]     data;
        logic [N-1:0]   br, bw, en;
        logic [16*N-1:0] div;
        logic [8*N-1:0] udw;
        bit             chk_irq;
        logic           irq;
    } exp_t;

    exp_t sbq[$];
    int   compared = 0, mismatched = 0;
    bit   probe = 1'b0, probe_d = 1'b0;

    // Register model
    logic [7:0]  ctrl_m[N], mask_m[N], pend_m[N], sh_m[N], udw_m[N];
    logic [15:0] div_m[N];
    logic [N-1:0] prv_rxp, prv_rxf, prv_txp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every probed cycle's outputs are visible at the following negedge.
    always @(posedge clk) probe_d <= probe;
    always @(negedge clk) begin
        if (probe_d) begin
            if (sbq.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL scoreboard: got empty queue expected entry");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.chk_data) chk({e.name, " data_out"}, 32'(data_out), 32'(e.data));
                chk({e.name, " buffer_read"}, 32'(buffer_read), 32'(e.br));
                chk({e.name, " buffer_write"}, 32'(buffer_write), 32'(e.bw));
                chk({e.name, " enable"}, 32'(enable), 32'(e.en));
                chk({e.name, " divide"}, uart_clock_divide, e.div);
                chk({e.name, " tx_data"}, 32'(uart_data_write), 32'(e.udw));
                if (e.chk_irq) chk({e.name, " interrupt"}, 32'(interrupt), 32'(e.irq));
            end
        end
    end

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            ctrl_m[c] = 8'h00; mask_m[c] = 8'h00; pend_m[c] = 8'h00;
            sh_m[c] = 8'd54; div_m[c] = 16'd54; udw_m[c] = 8'h00;
        end
        prv_rxp = rxp; prv_rxf = rxf; prv_txp = txp;
    endtask

    // One bus cycle, issued at a negedge; flags/udr must already hold this cycle's values.
    task automatic do_cycle(input bit wr, input bit rd, input bit ack, input logic [7:0] port,
                            input logic [7:0] data, input string name, input bit ci, input logic ei);
        exp_t e;
        int ch, off;
        logic [7:0] rv;
        ch = int'(port) / 8;
        off = int'(port) % 8;
        rv = 8'h00;
        if (port == 8'h10) begin
            for (int c = 0; c < N; c++) rv[c] = |(pend_m[c] & mask_m[c]);
        end else if (ch < N) begin
            case (off)
                0: rv = rxp[ch] ? udr[8*ch +: 8] : 8'h00;
                1: rv = ctrl_m[ch];
                2: rv = {2'b00, txf[ch], txh[ch], txp[ch], rxf[ch], rxh[ch], rxp[ch]};
                3: rv = mask_m[ch];
                4: rv = pend_m[ch];
                5: rv = sh_m[ch];
                6: rv = div_m[ch][15:8];
                default: rv = 8'h00;
            endcase
        end
        e.name = name; e.chk_data = rd; e.data = rv; e.chk_irq = ci; e.irq = ei;
        e.br = '0; e.bw = '0;
        if (rd && ch < N && off == 0 && rxp[ch]) e.br[ch] = 1'b1;
        for (int c = 0; c < N; c++) begin
            logic [7:0] s, clr;
            s = {5'b0, prv_txp[c] & ~txp[c], rxf[c] & ~prv_rxf[c], rxp[c] & ~prv_rxp[c]};
            clr = 8'h00;
            if (wr && ch == c) begin
                case (off)
                    0: if (txf[c]) s[3] = 1'b1; else begin e.bw[c] = 1'b1; udw_m[c] = data; end
                    1: ctrl_m[c] = data;
                    3: mask_m[c] = {4'h0, data[3:0]};
                    4: clr = {4'h0, data[3:0]};
                    5: sh_m[c] = data;
                    6: div_m[c] = {data, sh_m[c]};
                    default: ;
                endcase
            end
            pend_m[c] = (pend_m[c] & ~clr) | s;
            e.en[c] = ctrl_m[c][0];
            e.div[16*c +: 16] = div_m[c];
            e.udw[8*c +: 8] = udw_m[c];
        end
        prv_rxp = rxp; prv_rxf = rxf; prv_txp = txp;
        sbq.push_back(e);
        port_id = port; data_in = data; write_strobe = wr; read_strobe = rd;
        interrupt_ack = ack; probe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0; probe = 1'b0;
    endtask

    task automatic wr_io(input logic [7:0] p, input logic [7:0] d, input string nm);
        do_cycle(1, 0, 0, p, d, nm, 0, 1'b0);
    endtask
    task automatic rd_io(input logic [7:0] p, input string nm);
        do_cycle(0, 1, 0, p, 8'h00, nm, 0, 1'b0);
    endtask
    task automatic irq_chk(input logic exp, input string nm);
        do_cycle(0, 0, 0, 8'hFF, 8'h00, nm, 1, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        model_reset();
        reset = 1'b0;
        // Reset state
        do_cycle(0, 1, 0, 8'h0D, 8'h00, "rst_divlo", 1, 1'b0);
        do_cycle(0, 1, 0, 8'h0E, 8'h00, "rst_divhi", 1, 1'b0);
        do_cycle(0, 1, 0, 8'h09, 8'h00, "rst_ctrl", 1, 1'b0);
        // Atomic divisor
        wr_io(8'h0D, 8'h05, "div_lo_wr");
        wr_io(8'h0E, 8'h01, "div_hi_wr");
        rd_io(8'h0D, "div_lo_rd");
        wr_io(8'h01, 8'h01, "ctrl_en0");
        // RX read with and without data
        rxp[0] = 1'b1; udr[7:0] = 8'hA5;
        rd_io(8'h00, "rx_pop");
        irq_chk(1'b0, "rx_pop_after");
        rxp[0] = 1'b0;
        rd_io(8'h00, "rx_empty");
        do_cycle(0, 0, 0, 8'h00, 8'h00, "hold_port", 0, 1'b0);
        // TX overflow on ch1 and W1C
        txf[1] = 1'b1;
        wr_io(8'h08, 8'h55, "tx_ovf");
        rd_io(8'h0C, "pend_ovf");
        wr_io(8'h0C, 8'h08, "w1c_ovf");
        rd_io(8'h0C, "pend_clr");
        txf[1] = 1'b0;
        wr_io(8'h08, 8'h3C, "tx_ok");
        // Interrupt handshake
        wr_io(8'h04, 8'h0F, "clr_ch0");
        wr_io(8'h03, 8'h01, "mask1");
        rxp[0] = 1'b1;
        irq_chk(1'b0, "rx_rise");
        irq_chk(1'b1, "irq_set");
        do_cycle(0, 0, 1, 8'hFF, 8'h00, "irq_ack", 1, 1'b0);
        irq_chk(1'b0, "acked_hold");
        do_cycle(1, 0, 0, 8'h03, 8'h03, "mask3_acked", 1, 1'b0);
        rxf[0] = 1'b1;
        irq_chk(1'b1, "rxfull_new");
        do_cycle(0, 1, 0, 8'h10, 8'h00, "summary", 1, 1'b1);
        do_cycle(1, 0, 0, 8'h04, 8'h03, "w1c_irq", 1, 1'b1);
        irq_chk(1'b0, "irq_idle");
        // W1C racing a fresh rise: set wins
        rxp[0] = 1'b0;
        irq_chk(1'b0, "rx_fall");
        rxp[0] = 1'b1;
        wr_io(8'h04, 8'h01, "w1c_race");
        rd_io(8'h04, "pend_race");
        rd_io(8'h07, "reserved");
        rd_io(8'h11, "unmapped");
        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            int op;
            logic [7:0] p;
            if ($urandom_range(0, 3) == 0) begin
                rxp = N'($urandom); rxh = N'($urandom); rxf = N'($urandom);
                txp = N'($urandom); txh = N'($urandom); txf = N'($urandom);
            end
            udr = (8*N)'($urandom);
            op = int'($urandom_range(0, 2));
            p = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h17));
            do_cycle(op == 1, op == 2, $urandom_range(0, 7) == 0, p, 8'($urandom), "rnd", 0, 1'b0);
        end
        repeat (2) @(negedge clk);
        chk("queue_drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
